// File: rtl/lcd_timing_ctrl.sv
// ============================================================================
// Module   : lcd_timing_ctrl
// Brief    : RGB565 parallel LCD scan timing, pixel request coordinates,
//            panel strobes and delayed backlight enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_timing_ctrl #(
  parameter int H_SYNC   = 41,
  parameter int H_BACK   = 2,
  parameter int H_DISP   = 480,
  parameter int H_FRONT  = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BACK   = 2,
  parameter int V_DISP   = 272,
  parameter int V_FRONT  = 2,
  parameter int BL_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [15:0] lcd_rgb,
  output logic        lcd_bl,
  output logic        frame_start,
  output logic        busy
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [10:0] C_H_SYNC      = 11'(H_SYNC);
  localparam logic [10:0] C_V_SYNC      = 11'(V_SYNC);
  localparam logic [10:0] C_H_ACT_START = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] C_H_ACT_END   = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] C_V_ACT_START = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] C_V_ACT_END   = 11'(V_SYNC + V_BACK + V_DISP);
  localparam logic [10:0] C_H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] C_V_LAST      = 11'(V_TOTAL - 1);
  localparam logic [2:0]  C_BL_DELAY    = 3'(BL_DELAY);
  localparam logic [2:0]  C_FRAME_SAT   = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [10:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic [2:0]  r_frame_cnt;
  logic [2:0]  w_frame_cnt_next;
  logic        w_run;
  logic        w_h_end;
  logic        w_frame_end;
  logic        w_req;

  assign w_run       = (r_state == ST_RUN);
  assign w_h_end     = (r_h_cnt == C_H_LAST);
  assign w_frame_end = w_run && w_h_end && (r_v_cnt == C_V_LAST);
  assign w_req       = w_run
                     && (r_h_cnt >= C_H_ACT_START) && (r_h_cnt < C_H_ACT_END)
                     && (r_v_cnt >= C_V_ACT_START) && (r_v_cnt < C_V_ACT_END);

  // Coordinates lead lcd_de by one clock to cover the generator's register stage.
  assign pixel_xpos = w_req ? (r_h_cnt - C_H_ACT_START + 11'd1) : '0;
  assign pixel_ypos = w_req ? (r_v_cnt - C_V_ACT_START + 11'd1) : '0;
  assign lcd_rgb    = lcd_de ? pixel_data : '0;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (en)                 w_next_state = ST_RUN;
      ST_RUN:  if (w_frame_end && !en) w_next_state = ST_IDLE;
      default:                         w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_frame_cnt_next = r_frame_cnt;
    if (w_next_state == ST_IDLE)
      w_frame_cnt_next = '0;
    else if (w_frame_end && (r_frame_cnt != C_FRAME_SAT))
      w_frame_cnt_next = r_frame_cnt + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_frame_cnt <= '0;
      lcd_hs      <= 1'b1;
      lcd_vs      <= 1'b1;
      lcd_de      <= 1'b0;
      lcd_bl      <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      busy        <= (w_next_state == ST_RUN);
      r_frame_cnt <= w_frame_cnt_next;
      // Backlight follows the next-state count so BL_DELAY=0 lights on the first RUN clock.
      lcd_bl      <= (w_next_state == ST_RUN) && (w_frame_cnt_next >= C_BL_DELAY);

      if (w_run && !w_frame_end) begin
        if (w_h_end) begin
          r_h_cnt <= '0;
          r_v_cnt <= r_v_cnt + 11'd1;
        end else begin
          r_h_cnt <= r_h_cnt + 11'd1;
        end
      end else begin
        r_h_cnt <= '0;
        r_v_cnt <= '0;
      end

      lcd_hs      <= !(w_run && (r_h_cnt < C_H_SYNC));
      lcd_vs      <= !(w_run && (r_v_cnt < C_V_SYNC));
      lcd_de      <= w_req;
      frame_start <= w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_timing_ctrl.sv
// ============================================================================
// Module   : tb_lcd_timing_ctrl
// Brief    : Randomized self-checking bench against a frame-position model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_timing_ctrl;

  localparam int HS = 3, HB = 2, HD = 8, HF = 2;
  localparam int VS = 2, VB = 1, VD = 4, VF = 1;
  localparam int BL = 2;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] pixel_data = '0;
  logic [10:0] pixel_xpos, pixel_ypos;
  logic        lcd_hs, lcd_vs, lcd_de, lcd_bl, frame_start, busy;
  logic [15:0] lcd_rgb;

  lcd_timing_ctrl #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
    .BL_DELAY(BL)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pixel_data (pixel_data),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .lcd_hs     (lcd_hs),
    .lcd_vs     (lcd_vs),
    .lcd_de     (lcd_de),
    .lcd_rgb    (lcd_rgb),
    .lcd_bl     (lcd_bl),
    .frame_start(frame_start),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: running flag, linear position within the frame, completed frames.
  bit m_run    = 1'b0;
  int m_t      = 0;
  int m_frames = 0;
  bit e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_fs = 1'b0, e_bl = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit m_req(input bit run, input int t);
    int h, v;
    h = t % HT;
    v = t / HT;
    return run && (h >= HS + HB) && (h < HS + HB + HD) && (v >= VS + VB) && (v < VS + VB + VD);
  endfunction

  function automatic int m_x(input bit run, input int t);
    return m_req(run, t) ? (t % HT) - (HS + HB) + 1 : 0;
  endfunction

  function automatic int m_y(input bit run, input int t);
    return m_req(run, t) ? (t / HT) - (VS + VB) + 1 : 0;
  endfunction

  task automatic step(input bit r, input bit e);
    logic [15:0] px;
    rst = r;
    en  = e;
    @(posedge clk);
    // Stub generator: registers the coordinates requested in the previous clock.
    px = 16'((m_y(m_run, m_t) % 32) * 2048 + m_x(m_run, m_t));
    pixel_data = px;
    if (r) begin
      m_run = 1'b0; m_t = 0; m_frames = 0;
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0; e_bl = 1'b0;
    end else begin
      e_hs = !(m_run && (m_t % HT) < HS);
      e_vs = !(m_run && (m_t / HT) < VS);
      e_de = m_req(m_run, m_t);
      e_fs = m_run && (m_t == 0);
      if (!m_run) begin
        if (e) begin m_run = 1'b1; m_t = 0; end
      end else if (m_t == FT - 1) begin
        m_t = 0;
        if (m_frames < 7) m_frames++;
        if (!e) begin m_run = 1'b0; m_frames = 0; end
      end else begin
        m_t++;
      end
      e_bl = m_run && (m_frames >= BL);
    end
    #1;
    check("lcd_hs", 16'(lcd_hs), 16'(e_hs));
    check("lcd_vs", 16'(lcd_vs), 16'(e_vs));
    check("lcd_de", 16'(lcd_de), 16'(e_de));
    check("frame_start", 16'(frame_start), 16'(e_fs));
    check("lcd_bl", 16'(lcd_bl), 16'(e_bl));
    check("busy", 16'(busy), 16'(m_run));
    check("pixel_xpos", 16'(pixel_xpos), 16'(m_x(m_run, m_t)));
    check("pixel_ypos", 16'(pixel_ypos), 16'(m_y(m_run, m_t)));
    check("lcd_rgb", lcd_rgb, e_de ? px : 16'h0);
  endtask

  initial begin
    bit en_state;
    bit r;
    repeat (3) step(1'b1, 1'b1);
    // Continuous run across several frames: backlight must rise after BL frames.
    repeat (3 * FT + 10) step(1'b0, 1'b1);
    // Drop en mid-frame, let the frame finish, idle a while, then restart.
    repeat (FT / 2) step(1'b0, 1'b1);
    repeat (FT + 20) step(1'b0, 1'b0);
    repeat (3 * FT) step(1'b0, 1'b1);
    // Reset pulse mid-line with en held high.
    repeat (FT / 3) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (FT + 5) step(1'b0, 1'b1);
    // Random en toggling with occasional reset pulses.
    en_state = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) en_state = !en_state;
      step(r, en_state);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
